// File: rtl/top_uart_tx_dzj.sv
// top_uart_tx_dzj: key-press to 8N1 UART transmitter (optional debounce via KEY_DEBOUNCE_EN)
module top_uart_tx_dzj #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD = 9600,
    parameter logic [7:0] CODE0 = 8'h31,
    parameter logic [7:0] CODE1 = 8'h32,
    parameter logic [7:0] CODE2 = 8'h33,
    parameter logic [7:0] CODE3 = 8'h34
`ifdef KEY_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 1_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_key_en,
    output logic       RX232,
    output logic       over_rx
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW = $clog2(BAUD_DIV + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] sh, sh_n;
    logic tx_n, over_n;
    logic [3:0] s1, s2, s3, lvl, rise;
    logic [7:0] code;
    logic last;

    // two-flop synchronizer for the asynchronous key inputs
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_key_en;
            s2 <= s1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    genvar i;
    for (i = 0; i < 4; i++) begin : g_deb
        logic [DW-1:0] dcnt;
        // level follows s2 only after it has differed for DEBOUNCE_CYCLES clocks
        always_ff @(posedge clk) begin
            if (rst_n) begin
                dcnt <= '0;
                lvl[i] <= 1'b0;
            end else if (s2[i] == lvl[i]) begin
                dcnt <= '0;
            end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                dcnt <= '0;
                lvl[i] <= s2[i];
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end
`else
    assign lvl = s2;
`endif

    // history flop; cleared at reset so a key held through reset fires once
    always_ff @(posedge clk) begin
        if (rst_n) s3 <= '0;
        else s3 <= lvl;
    end

    assign rise = lvl & ~s3;
    assign code = rise[0] ? CODE0 : rise[1] ? CODE1 : rise[2] ? CODE2 : CODE3;
    assign last = cnt == CW'(BAUD_DIV - 1);

    // FSM and datapath registers; outputs are registered
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            sh <= '0;
            RX232 <= 1'b1;
            over_rx <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bit_idx <= bit_n;
            sh <= sh_n;
            RX232 <= tx_n;
            over_rx <= over_n;
        end
    end

    // next-state logic: baud counter clears on every state change
    always_comb begin
        state_n = state;
        cnt_n = cnt + CW'(1);
        bit_n = bit_idx;
        sh_n = sh;
        tx_n = RX232;
        over_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n = 1'b1;
                if (|rise) begin
                    state_n = START;
                    tx_n = 1'b0;
                    sh_n = code;
                end
            end
            START: if (last) begin
                state_n = DATA;
                cnt_n = '0;
                bit_n = '0;
                tx_n = sh[0];
            end
            DATA: if (last) begin
                cnt_n = '0;
                if (bit_idx == 3'd7) begin
                    state_n = STOP;
                    tx_n = 1'b1;
                end else begin
                    bit_n = bit_idx + 3'd1;
                    sh_n = sh >> 1;
                    tx_n = sh[1];
                end
            end
            STOP: if (last) begin
                state_n = IDLE;
                cnt_n = '0;
                tx_n = 1'b1;
                over_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_top_uart_tx_dzj.sv
// tb_top_uart_tx_dzj: directed bench for the key-to-UART transmitter
module tb_top_uart_tx_dzj;
    localparam int D = 50_000_000 / 115200;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] in_key_en = 4'b0000;
    logic RX232, over_rx;
    int n_checks = 0, n_fail = 0;
    int lows = 0, pulses = 0;
    int l0, p0;

    top_uart_tx_dzj #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut (
        .clk(clk), .rst_n(rst_n), .in_key_en(in_key_en), .RX232(RX232), .over_rx(over_rx)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (RX232 === 1'b0) lows++;
        if (over_rx === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v, input string tag);
        in_key_en = v;
        step(2);
        check({tag, "_early"}, RX232, 1);
        step(1);
        check({tag, "_start"}, RX232, 0);
    endtask

    task automatic recv(input logic [7:0] exp, input string tag);
        logic [7:0] b;
        int ov;
        ov = pulses;
        step(D / 2);
        check({tag, "_startmid"}, RX232, 0);
        for (int k = 0; k < 8; k++) begin
            step(D);
            b[k] = RX232;
        end
        step(D);
        check({tag, "_stop"}, RX232, 1);
        check({tag, "_byte"}, b, exp);
        step(D - D / 2 - 1);
        check({tag, "_over_early"}, over_rx, 0);
        step(1);
        check({tag, "_over"}, over_rx, 1);
        step(1);
        check({tag, "_over_once"}, pulses - ov, 1);
        check({tag, "_over_drop"}, over_rx, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("rst_tx", RX232, 1);
            check("rst_over", over_rx, 0);
        end
        rst_n = 1'b0;
        l0 = lows;
        p0 = pulses;
        step(20000);
        check("idle_lows", lows - l0, 0);
        check("idle_pulses", pulses - p0, 0);

        press(4'b0100, "k2");
        recv(8'h33, "k2");
        l0 = lows;
        step(50000 - 3 - 10 * D - 1);
        check("k2_hold_lows", lows - l0, 0);

        in_key_en = 4'b0000;
        step(5);
        press(4'b1010, "k13");
        recv(8'h32, "k13");

        in_key_en = 4'b0000;
        step(5);
        p0 = pulses;
        press(4'b0001, "k0");
        fork
            recv(8'h31, "k0");
            begin
                repeat (997) @(posedge clk);
                #2 in_key_en = 4'b0011;
            end
        join
        l0 = lows;
        step(1000);
        check("k0_no_retx", lows - l0, 0);
        check("k0_pulses", pulses - p0, 1);

        in_key_en = 4'b0000;
        step(5);
        press(4'b0100, "ab");
        step(2000);
        check("ab_midbit", RX232, 0);
        p0 = pulses;
        rst_n = 1'b1;
        step(1);
        check("ab_tx", RX232, 1);
        check("ab_over", over_rx, 0);
        rst_n = 1'b0;
        step(2);
        check("ab_rel_early", RX232, 1);
        step(1);
        check("ab_rel_start", RX232, 0);
        check("ab_no_over", pulses - p0, 0);
        recv(8'h33, "ab");

        press(4'b1000, "k3");
        recv(8'h34, "k3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
